vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates the 640x480@60 Hz VGA raster timing that drives the pixel renderer and the DAC. Free-running horizontal and vertical counters are published as VGA_X/VGA_Y in raw counter space, with visible pixels at X 144..783 and Y 35..514, so the renderer computes RGB from them. Sync and blank outputs are delayed through a PIPE-stage pipeline so they line up with the renderer's registered RGB. A start-of-frame pulse and a frame counter are also provided for game-logic pacing.

## Interface
- H_SYNC, 96: horizontal sync width in clocks.
- H_BACK, 48: horizontal back porch.
- H_VIS, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch.
- V_SYNC, 2: vertical sync width in lines.
- V_BACK, 33: vertical back porch.
- V_VIS, 480: visible lines.
- V_FRONT, 10: vertical front porch.
- PIPE, 1: delay stages on HS/VS/BLANK_N (1..4); equals renderer RGB latency.

Ports:
- VGA_CLK  in  1  pixel clock, 25.175 MHz nominal.
- reset  in  1  reset, asynchronous, active-high; clock VGA_CLK.
- VGA_X  out  10  horizontal counter, 0..H_TOTAL-1 (H_TOTAL = sum of H_*, 800).
- VGA_Y  out  10  vertical counter, 0..V_TOTAL-1 (V_TOTAL = 525).
- pixel_visible  out  1  high when the current VGA_X/VGA_Y is in the active area (undelayed).
- VGA_HS  out  1  horizontal sync, active-low, delayed PIPE cycles.
- VGA_VS  out  1  vertical sync, active-low, delayed PIPE cycles.
- VGA_BLANK_N  out  1  high in the active area, delayed PIPE cycles.
- VGA_SYNC_N  out  1  tied 0 (no sync-on-green).
- frame_start  out  1  one-cycle pulse, registered.
- frame_count  out  8  frames completed, modulo 256.

## Operation
- Counter rules:
  - VGA_X increments every cycle.
  - At H_TOTAL-1, VGA_X wraps to 0 and VGA_Y increments.
  - At (H_TOTAL-1, V_TOTAL-1), both counters wrap to 0.
- Raw decode from the counters:
  - hs_raw = 0 iff X < H_SYNC.
  - vs_raw = 0 iff Y < V_SYNC.
  - visible iff H_SYNC+H_BACK ≤ X < H_SYNC+H_BACK+H_VIS and V_SYNC+V_BACK ≤ Y < V_SYNC+V_BACK+V_VIS.
  - With the default parameters this gives X 144..783 and Y 35..514.
- pixel_visible is the undelayed visible term.
- A PIPE-deep shift register carries {hs_raw, vs_raw, visible} to VGA_HS, VGA_VS and VGA_BLANK_N.
- frame_start is registered high for exactly one cycle: the cycle in which VGA_X=0 and VGA_Y=0. This includes the first cycle after reset release.
- frame_count increments by 1 on the wrap from (799,524) to (0,0) and wraps 255→0. It does not increment on reset release.
- Width rules: counters are 10 bits; the compare constants are computed at elaboration. Parameters with H_TOTAL > 1023 or V_TOTAL > 1023 are illegal; a simulation assertion fires.
- No states beyond the counters. The design is a strict two-level counter with no enable, so pixel cadence is fixed.

## Timing
- Reset values (reset asserted):
  - VGA_X=0, VGA_Y=0, frame_count=0, frame_start=0.
  - Every pipeline stage = {HS=1, VS=1, BLANK_N=0}, so VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0.
  - VGA_SYNC_N=0.
- First rising edge after reset deasserts:
  - X becomes 1.
  - The counters are 0,0 in the cycle immediately following deassertion, and frame_start=1 in that cycle.
- Reset mid-frame: all outputs return to reset values asynchronously, with no partial-frame completion and no frame_count increment.
- Latency: VGA_HS, VGA_VS and VGA_BLANK_N reflect the counter value from exactly PIPE cycles earlier. With PIPE=1, VGA_HS falls in the cycle when VGA_X=1.
- Line period is exactly 800 clocks; frame period is exactly 420000 clocks.
- Simultaneous events at (799,524): the Y wrap, X wrap and frame_count increment all occur on the same edge.

## Test plan
- Reset release, PIPE=1 -> cycle 0: X=0, Y=0, frame_start=1, VGA_HS=1 (reset stage); cycle 1: VGA_HS=0, frame_start=0.
- Run one line -> VGA_HS low for exactly 96 cycles; VGA_BLANK_N high for exactly 640 cycles, starting when X=145; Y increments to 1 when X wraps 799→0.
- Run one full frame -> VGA_VS low for 2×800 clocks; 480 lines contain an active interval; frame_start repeats after 420000 clocks; frame_count=1.
- Run 256 frames -> frame_count wraps 255→0; frame_start is seen exactly 257 times including the initial pulse.
- Assert reset at X=400, Y=200 for 3 cycles -> outputs take reset values immediately; after release the counters restart at 0,0 and frame_count=0.
- PIPE=3 -> VGA_BLANK_N rises when X=147 on line Y=35; pixel_visible rises when X=144.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA raster timing: free-running X/Y counters,
// pipelined sync/blank, start-of-frame pulse and frame counter.
module vga_timing_gen #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_VIS   = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_VIS   = 480,
  parameter int V_FRONT = 10,
  parameter int PIPE    = 1
) (
  input  logic       VGA_CLK,
  input  logic       reset,
  output logic [9:0] VGA_X,
  output logic [9:0] VGA_Y,
  output logic       pixel_visible,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VIS + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VIS + V_FRONT;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
  localparam logic [9:0] H_VIS_BEG  = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_VIS_END  = 10'(H_SYNC + H_BACK + H_VIS);
  localparam logic [9:0] V_VIS_BEG  = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_VIS_END  = 10'(V_SYNC + V_BACK + V_VIS);

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic [7:0] r_frame_count;
  logic       r_frame_start;
  logic       r_post_reset;
  logic [2:0] r_pipe [PIPE];

  logic w_x_last;
  logic w_y_last;
  logic w_wrap;
  logic w_hs_raw;
  logic w_vs_raw;
  logic w_visible;

  assign w_x_last  = (r_x == H_LAST);
  assign w_y_last  = (r_y == V_LAST);
  assign w_wrap    = w_x_last && w_y_last;
  assign w_hs_raw  = !(r_x < H_SYNC_END);
  assign w_vs_raw  = !(r_y < V_SYNC_END);
  assign w_visible = (r_x >= H_VIS_BEG) && (r_x < H_VIS_END) &&
                     (r_y >= V_VIS_BEG) && (r_y < V_VIS_END);

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_x_last) begin
      r_x <= '0;
      r_y <= w_y_last ? '0 : r_y + 10'd1;
    end else begin
      r_x <= r_x + 10'd1;
    end
  end

  // r_post_reset covers the (0,0) cycle right after release, which no clock edge precedes.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      r_frame_count <= '0;
      r_frame_start <= 1'b0;
      r_post_reset  <= 1'b1;
    end else begin
      r_frame_count <= r_frame_count + {7'd0, w_wrap};
      r_frame_start <= w_wrap;
      r_post_reset  <= 1'b0;
    end
  end

  // Stage bits are {hs, vs, blank_n}; reset value is the idle {1, 1, 0}.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE; i++) r_pipe[i] <= 3'b110;
    end else begin
      r_pipe[0] <= {w_hs_raw, w_vs_raw, w_visible};
      for (int i = 1; i < PIPE; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  always @(posedge VGA_CLK) begin
    assert (H_TOTAL <= 1023 && V_TOTAL <= 1023 && PIPE >= 1 && PIPE <= 4)
      else $error("vga_timing_gen: illegal timing parameters");
  end

  assign VGA_X         = r_x;
  assign VGA_Y         = r_y;
  assign pixel_visible = w_visible;
  assign VGA_HS        = r_pipe[PIPE-1][2];
  assign VGA_VS        = r_pipe[PIPE-1][1];
  assign VGA_BLANK_N   = r_pipe[PIPE-1][0];
  assign VGA_SYNC_N    = 1'b0;
  assign frame_start   = r_frame_start | (r_post_reset & ~reset);
  assign frame_count   = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen: default timing
// (PIPE=1 and PIPE=3) plus a shrunken raster for frame-level behaviour.
module tb_vga_timing_gen;

  localparam int C_HS = 4, C_HB = 3, C_HV = 8, C_HF = 2;
  localparam int C_VS = 2, C_VB = 2, C_VV = 4, C_VF = 1;
  localparam int C_HT = C_HS + C_HB + C_HV + C_HF;
  localparam int C_VT = C_VS + C_VB + C_VV + C_VF;
  localparam int C_FRAME = C_HT * C_VT;
  localparam int C_PIPE = 2;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_c = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
  logic a_vis, a_hs, a_vs, a_bl, a_sn, a_fs;
  logic b_vis, b_hs, b_vs, b_bl, b_sn, b_fs;
  logic c_vis, c_hs, c_vs, c_bl, c_sn, c_fs;
  logic [7:0] a_fc, b_fc, c_fc;

  vga_timing_gen #(.PIPE(1)) u_a (
    .VGA_CLK(clk), .reset(rst_a), .VGA_X(a_x), .VGA_Y(a_y), .pixel_visible(a_vis),
    .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_N(a_bl), .VGA_SYNC_N(a_sn),
    .frame_start(a_fs), .frame_count(a_fc));

  vga_timing_gen #(.PIPE(3)) u_b (
    .VGA_CLK(clk), .reset(rst_a), .VGA_X(b_x), .VGA_Y(b_y), .pixel_visible(b_vis),
    .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_bl), .VGA_SYNC_N(b_sn),
    .frame_start(b_fs), .frame_count(b_fc));

  vga_timing_gen #(.H_SYNC(C_HS), .H_BACK(C_HB), .H_VIS(C_HV), .H_FRONT(C_HF),
                   .V_SYNC(C_VS), .V_BACK(C_VB), .V_VIS(C_VV), .V_FRONT(C_VF),
                   .PIPE(C_PIPE)) u_c (
    .VGA_CLK(clk), .reset(rst_c), .VGA_X(c_x), .VGA_Y(c_y), .pixel_visible(c_vis),
    .VGA_HS(c_hs), .VGA_VS(c_vs), .VGA_BLANK_N(c_bl), .VGA_SYNC_N(c_sn),
    .frame_start(c_fs), .frame_count(c_fc));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent model of the small raster: {hs, vs, visible} for a counter position.
  function automatic logic [2:0] c_raw(input int x, input int y);
    logic h, v, vis;
    h   = (x >= C_HS);
    v   = (y >= C_VS);
    vis = (x >= C_HS + C_HB) && (x < C_HS + C_HB + C_HV) &&
          (y >= C_VS + C_VB) && (y < C_VS + C_VB + C_VV);
    return {h, v, vis};
  endfunction

  // Scoreboard for u_c: expected sync/blank pushed per cycle, popped PIPE cycles later.
  logic [2:0] sb_q[$];
  int mx = 0, my = 0;
  logic [7:0] mfc = 8'd0;

  always @(negedge clk) begin
    logic [2:0] r;
    if (rst_c) begin
      chk("c_reset_state", {c_x, c_y, c_fs, c_fc, c_hs, c_vs, c_bl, c_sn},
          {10'd0, 10'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0});
      mx = 0; my = 0; mfc = 8'd0;
      sb_q.delete();
      repeat (C_PIPE) sb_q.push_back(3'b110);
    end else begin
      r = c_raw(mx, my);
      chk("c_scoreboard", {c_x, c_y, c_fs, c_fc, c_hs, c_vs, c_bl, c_vis},
          {10'(mx), 10'(my), 1'(mx == 0 && my == 0), mfc, sb_q[0], r[0]});
      sb_q.push_back({r[2], r[1], r[0]});
      void'(sb_q.pop_front());
      if (mx == C_HT - 1) begin
        mx = 0;
        if (my == C_VT - 1) begin my = 0; mfc = mfc + 8'd1; end
        else my = my + 1;
      end else begin
        mx = mx + 1;
      end
    end
  end

  typedef struct {
    bit   use_b;
    int   x;
    int   y;
    logic hs, vs, bl, vis;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input bit b, input int x, input int y,
                              input logic hs, input logic vs, input logic bl, input logic vis);
    vec_t v;
    v.use_b = b; v.x = x; v.y = y; v.hs = hs; v.vs = vs; v.bl = bl; v.vis = vis;
    return v;
  endfunction

  task automatic wait_a(input int x, input int y, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (a_x == 10'(x) && a_y == 10'(y)) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk($sformatf("wait_a_%0d_%0d", x, y), 64'd0, 64'd1);
  endtask

  task automatic run_a;
    int hs_low = 0, vs_low = 0, bl_cnt = 0;
    int a_first = -1, b_first_bl = -1, b_first_vis = -1;
    bit ok;
    for (int n = 0; n < 36 * 800; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 0) begin
        chk("a_c0_xy", {a_x, a_y}, 20'd0);
        chk("a_c0_fs", a_fs, 1'b1);
        chk("a_c0_hs", a_hs, 1'b1);
      end
      if (n == 1) begin
        chk("a_c1_x", a_x, 10'd1);
        chk("a_c1_hs", a_hs, 1'b0);
        chk("a_c1_fs", a_fs, 1'b0);
      end
      if (n == 800) chk("a_line_wrap", {a_x, a_y}, {10'd0, 10'd1});
      if (n < 800 && !a_hs) hs_low++;
      if (!a_vs) vs_low++;
      if (a_y == 10'd35 && a_bl) begin
        bl_cnt++;
        if (a_first < 0) a_first = int'(a_x);
      end
      if (b_y == 10'd35 && b_bl && b_first_bl < 0) b_first_bl = int'(b_x);
      if (b_y == 10'd35 && b_vis && b_first_vis < 0) b_first_vis = int'(b_x);
    end
    chk("a_hs_low_len", 32'(hs_low), 32'd96);
    chk("a_vs_low_len", 32'(vs_low), 32'd1600);
    chk("a_blank_len", 32'(bl_cnt), 32'd640);
    chk("a_blank_first_x", 32'(a_first), 32'd145);
    chk("b_blank_first_x", 32'(b_first_bl), 32'd147);
    chk("b_vis_first_x", 32'(b_first_vis), 32'd144);

    for (int i = 0; i < 15; i++) begin
      wait_a(vecs[i].x, vecs[i].y, ok);
      if (ok) begin
        chk($sformatf("vec%0d_hs", i), vecs[i].use_b ? b_hs : a_hs, vecs[i].hs);
        chk($sformatf("vec%0d_vs", i), vecs[i].use_b ? b_vs : a_vs, vecs[i].vs);
        chk($sformatf("vec%0d_bl", i), vecs[i].use_b ? b_bl : a_bl, vecs[i].bl);
        chk($sformatf("vec%0d_vis", i), vecs[i].use_b ? b_vis : a_vis, vecs[i].vis);
      end
    end

    wait_a(399, 37, ok);
    @(posedge clk);
    #1 rst_a = 1'b1;
    #1;
    chk("a_midrst_async", {a_x, a_y, a_fs, a_fc, a_hs, a_vs, a_bl, b_hs, b_bl},
        {10'd0, 10'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b0;
    @(negedge clk);
    chk("a_after_rst_c0", {a_x, a_y, a_fs, a_fc, a_hs}, {10'd0, 10'd0, 1'b1, 8'd0, 1'b1});
    @(negedge clk);
    chk("a_after_rst_c1", {a_x, a_fs, a_hs}, {10'd1, 1'b0, 1'b0});
  endtask

  task automatic run_c;
    int fs_cnt = 0;
    bit ok;
    for (int n = 0; n <= 256 * C_FRAME; n++) begin
      if (n > 0) @(negedge clk);
      if (c_fs) fs_cnt++;
      if (n == C_FRAME) chk("c_fc_one_frame", c_fc, 8'd1);
      if (n == 255 * C_FRAME) chk("c_fc_255", c_fc, 8'd255);
    end
    chk("c_fc_wrap", c_fc, 8'd0);
    chk("c_fs_count", 32'(fs_cnt), 32'd257);
    ok = 1'b0;
    for (int k = 0; k < 2 * C_FRAME; k++) begin
      if (c_x == 10'd10 && c_y == 10'd5) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("c_wait_mid", ok, 1'b1);
    @(posedge clk);
    #1 rst_c = 1'b1;
    #1;
    chk("c_midrst_async", {c_x, c_y, c_fs, c_fc, c_hs, c_vs, c_bl},
        {10'd0, 10'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0});
    repeat (3) @(posedge clk);
    #1 rst_c = 1'b0;
    @(negedge clk);
    chk("c_after_rst", {c_x, c_y, c_fs, c_fc}, {10'd0, 10'd0, 1'b1, 8'd0});
    repeat (2 * C_FRAME) @(negedge clk);
  endtask

  initial begin
    vecs[0]  = mk(0,   0, 36, 1, 1, 0, 0);
    vecs[1]  = mk(0,   1, 36, 0, 1, 0, 0);
    vecs[2]  = mk(0,  96, 36, 0, 1, 0, 0);
    vecs[3]  = mk(0,  97, 36, 1, 1, 0, 0);
    vecs[4]  = mk(0, 144, 36, 1, 1, 0, 1);
    vecs[5]  = mk(0, 145, 36, 1, 1, 1, 1);
    vecs[6]  = mk(1, 146, 36, 1, 1, 0, 1);
    vecs[7]  = mk(1, 147, 36, 1, 1, 1, 1);
    vecs[8]  = mk(0, 783, 36, 1, 1, 1, 1);
    vecs[9]  = mk(0, 784, 36, 1, 1, 1, 0);
    vecs[10] = mk(0, 785, 36, 1, 1, 0, 0);
    vecs[11] = mk(1, 786, 36, 1, 1, 1, 0);
    vecs[12] = mk(1, 787, 36, 1, 1, 0, 0);
    vecs[13] = mk(1,   2, 37, 1, 1, 0, 0);
    vecs[14] = mk(1,   3, 37, 0, 1, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("a_reset_state", {a_x, a_y, a_fs, a_fc, a_hs, a_vs, a_bl, a_sn, a_vis},
        {10'd0, 10'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("b_reset_state", {b_x, b_y, b_fs, b_hs, b_vs, b_bl, b_sn},
        {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_c = 1'b0;
    @(negedge clk);
    fork
      run_a();
      run_c();
    join
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
